alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be a power of two, 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 in_a  input  WIDTH  operand A, unsigned unless stated.
REQ-007 in_b  input  WIDTH  operand B, or shift amount.
REQ-008 select  input  4  opcode.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 alu_out  output  WIDTH  registered result.
REQ-012 flags  output  4  registered {N,Z,C,V}.

Function
REQ-013 Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shl, 0110 shr (logical), 0111 cmp, 1000 sar (arithmetic), 1001 mul; 1010..1111 give result 0 and flags 0.
REQ-014 Transfer in: an operation is accepted on a rising edge where in_valid=1 and in_ready=1; inputs are sampled only at that edge.
REQ-015 FSM states: IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE + accept of a non-mul opcode -> DONE, with result and flags registered at the accepting edge (1-cycle latency).
REQ-017 IDLE + accept of mul -> MUL; shift-add multiplier does one bit per cycle for exactly WIDTH cycles, then DONE; out_valid rises on the WIDTH-th edge after the accepting edge.
REQ-018 DONE + out_ready=1 -> IDLE on that edge; DONE + out_ready=0 -> stay, alu_out and flags held bit-stable.
REQ-019 in_valid while not in IDLE is ignored; no operation is queued or lost state-wise.
REQ-020 add/sub/mul results are modulo 2^WIDTH; mul returns the low WIDTH bits of the product.
REQ-021 Shift amount = in_b mod WIDTH (low log2(WIDTH) bits); sar replicates in_a MSB.
REQ-022 cmp (unsigned): 1 if a>b, 2 if a<b, 0 if equal, zero-extended to WIDTH.
REQ-023 N = result MSB; Z = (result==0), for every opcode.
REQ-024 C: add = carry out; sub = borrow (a<b unsigned); 0 for all other opcodes.
REQ-025 V: add/sub = two's-complement signed overflow; 0 for all other opcodes.
REQ-026 Simultaneous out_ready and in_valid in DONE: only the output transfer occurs; the new operation is accepted no earlier than the following edge, in IDLE.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, alu_out=0, flags=0, multiplier counter/accumulator=0, independent of clk.
REQ-028 Reset asserted mid-MUL or in DONE SHALL discard the operation; no result is ever presented for it.
REQ-029 After reset_n deasserts, the first rising edge SHALL be able to accept an operation.

Verification (WIDTH=16)
REQ-030 add 0xFFFF+0x0001 -> alu_out 0x0000, flags N0 Z1 C1 V0, out_valid high 1 cycle after accept.
REQ-031 sub 0x8000-0x0001 -> 0x7FFF, flags N0 Z0 C0 V1; cmp 5,9 -> 0x0002; shl 0x0001 by 17 -> 0x0002; sar 0x8000 by 4 -> 0xF800.
REQ-032 mul 0x0123*0x0010 -> 0x1230; out_valid rises exactly 16 edges after accept; in_ready low throughout; in_valid pulses during MUL ignored.
REQ-033 Backpressure: result ready, out_ready=0 for 3 cycles -> alu_out/flags/out_valid unchanged; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 reset_n pulsed low mid-MUL (cycle 7) -> out_valid=0, in_ready=1 without a clock edge; no result appears afterwards; next add is accepted normally.
REQ-035 Opcode 1111 with any operands -> alu_out 0, flags 0000, 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus a bit-serial shift-add multiplier.
// Valid/ready handshake on both sides, one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] res;
  logic             c_f, v_f, undef;
  logic [3:0]       res_flags;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    sum   = {1'b0, in_a} + {1'b0, in_b};
    diff  = in_a - in_b;
    sh    = in_b[SW-1:0];
    res   = '0;
    c_f   = 1'b0;
    v_f   = 1'b0;
    undef = 1'b0;
    case (select)
      4'b0000: begin
        res = sum[WIDTH-1:0];
        c_f = sum[WIDTH];
        v_f = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
              (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'b0001: begin
        res = diff;
        c_f = in_a < in_b;
        v_f = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
              (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'b0010: res = in_a & in_b;
      4'b0011: res = in_a | in_b;
      4'b0100: res = in_a ^ in_b;
      4'b0101: res = in_a << sh;
      4'b0110: res = in_a >> sh;
      4'b0111: begin
        if (in_a > in_b)      res = WIDTH'(1);
        else if (in_a < in_b) res = WIDTH'(2);
        else                  res = '0;
      end
      4'b1000: res = $unsigned($signed(in_a) >>> sh);
      default: undef = 1'b1;
    endcase
    // Unassigned opcodes report all-zero flags, including Z
    if (undef) res_flags = 4'b0000;
    else res_flags = {res[WIDTH-1], res == '0, c_f, v_f};
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (select == 4'b1001) begin
            state_d  = MUL;
            mcand_d  = in_a;
            mplier_d = in_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d   = DONE;
            alu_out_d = res;
            flags_d   = res_flags;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (cnt_q == LAST) begin
          state_d   = DONE;
          alu_out_d = acc_step;
          flags_d   = {acc_step[WIDTH-1], acc_step == '0, 2'b00};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      flags_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_out   = alu_out_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16.
// Expected results and flags are hand-computed constants.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  select;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] sel,
                      input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge clk);
    check("rdy_before", in_ready, 1'b1);
    in_valid = 1'b1;
    select   = sel;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_rdy", in_ready, 1'b1);
    check("drain_ov", out_valid, 1'b0);
  endtask

  task automatic op(input string tag, input logic [3:0] sel,
                    input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] er, input logic [3:0] ef);
    send(sel, a, b);
    check({tag, "_ov"}, out_valid, 1'b1);
    check({tag, "_res"}, alu_out, er);
    check({tag, "_flg"}, flags, ef);
    drain();
  endtask

  int seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    select    = '0;
    #2;
    check("rst_rdy", in_ready, 1'b1);
    check("rst_ov", out_valid, 1'b0);
    check("rst_out", alu_out, 16'h0000);
    check("rst_flg", flags, 4'b0000);
    #5 reset_n = 1'b1;

    // flags are {N,Z,C,V}
    op("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
    op("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    op("sub_ovf",  4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    op("sub_brw",  4'h1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010);
    op("and",      4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000);
    op("or",       4'h3, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
    op("xor",      4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100);
    op("shl17",    4'h5, 16'h0001, 16'h0011, 16'h0002, 4'b0000);
    op("shl16",    4'h5, 16'h0003, 16'h0010, 16'h0003, 4'b0000);
    op("shr15",    4'h6, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
    op("cmp_lt",   4'h7, 16'h0005, 16'h0009, 16'h0002, 4'b0000);
    op("cmp_gt",   4'h7, 16'h0009, 16'h0005, 16'h0001, 4'b0000);
    op("cmp_eq",   4'h7, 16'h0007, 16'h0007, 16'h0000, 4'b0100);
    op("sar4",     4'h8, 16'h8000, 16'h0004, 16'hF800, 4'b1000);
    op("undef_f",  4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b0000);
    op("undef_a",  4'hA, 16'h0000, 16'h0000, 16'h0000, 4'b0000);

    // mul: 16 serial steps, extra in_valid pulses must be ignored
    send(4'h9, 16'h0123, 16'h0010);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      in_valid = (i % 3 == 0);
      select   = 4'h0;
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      @(posedge clk);
      #1;
      if (i < 16) begin
        check("mul_busy_ov", out_valid, 1'b0);
        check("mul_busy_rdy", in_ready, 1'b0);
      end
    end
    in_valid = 1'b0;
    check("mul_ov", out_valid, 1'b1);
    check("mul_res", alu_out, 16'h1230);
    check("mul_flg", flags, 4'b0000);

    // backpressure: result held while consumer stalls
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_ov", out_valid, 1'b1);
      check("bp_res", alu_out, 16'h1230);
      check("bp_flg", flags, 4'b0000);
      check("bp_rdy", in_ready, 1'b0);
    end
    drain();

    send(4'h9, 16'hFFFF, 16'hFFFF);
    seen = 0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check("mul2_lat", seen, 16);
    check("mul2_res", alu_out, 16'h0001);
    check("mul2_flg", flags, 4'b0000);
    drain();

    // out_ready and in_valid together in DONE: output transfer only
    send(4'h0, 16'h0001, 16'h0001);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    select    = 4'h0;
    in_a      = 16'h0010;
    in_b      = 16'h0020;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("sim_ov", out_valid, 1'b0);
    check("sim_rdy", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("sim2_ov", out_valid, 1'b1);
    check("sim2_res", alu_out, 16'h0030);
    drain();

    // reset pulse mid-multiply
    send(4'h9, 16'h0005, 16'h0003);
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_ov", out_valid, 1'b0);
    check("mrst_rdy", in_ready, 1'b1);
    check("mrst_out", alu_out, 16'h0000);
    check("mrst_flg", flags, 4'b0000);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mrst_noresult", seen, 0);
    op("post_rst", 4'h0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
